// File: rtl/wb_response_decoder.sv
// Decodes Wishbone executor response words: routes read data to a host FIFO or the
// ADC FIFO port, tracks the last bus address, counts write acks and keeps sticky flags.
module wb_response_decoder #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] ADC_ADDR = 32'h0000_0001,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_rsp_stb,
    input  logic [33:0]                i_rsp_word,
    input  logic                       host_rd_en,
    output logic [31:0]                host_dout,
    output logic                       host_empty,
    output logic                       host_full,
    output logic [$clog2(DEPTH):0]     host_count,
    input  logic                       adc_full,
    output logic                       adc_wr_en,
    output logic [31:0]                adc_data,
    output logic [31:0]                last_addr,
    output logic [CNT_W-1:0]           wr_ack_count,
    input  logic                       err_clr,
    input  logic                       int_clr,
    output logic                       err_flag,
    output logic                       int_flag,
    output logic                       host_ovf,
    output logic                       adc_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        PUSH_HOST,
        PUSH_ADC
    } state_t;

    state_t      state, state_next;
    logic [31:0] payload_q;
    logic        host_push;
    logic        adc_load;
    logic        adc_pend;

    logic [1:0]  rsp_type;
    logic [31:0] rsp_payload;
    logic        is_ack, is_echo, is_err, is_bus_rst, is_int;

    assign rsp_type    = i_rsp_word[33:32];
    assign rsp_payload = i_rsp_word[31:0];
    assign is_ack      = i_rsp_stb && (rsp_type == 2'b00);
    assign is_echo     = i_rsp_stb && (rsp_type == 2'b10);
    assign is_err      = i_rsp_stb && (rsp_type == 2'b11) && (rsp_payload == 32'd0);
    assign is_bus_rst  = i_rsp_stb && (rsp_type == 2'b11) && (rsp_payload == 32'd1);
    assign is_int      = i_rsp_stb && (rsp_type == 2'b11) && (rsp_payload == 32'd2);

    // The state names the slot holding the word captured on the previous strobe;
    // it is overwritten every cycle, so back-to-back strobes flow through.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            payload_q <= '0;
        end else begin
            state <= state_next;
            if (i_rsp_stb)
                payload_q <= rsp_payload;
        end
    end

    // Routing reads the registered last_addr, so an echo on the previous cycle is already in effect.
    always_comb begin
        state_next = IDLE;
        if (i_rsp_stb) begin
            if (rsp_type == 2'b01)
                state_next = (last_addr == ADC_ADDR) ? PUSH_ADC : PUSH_HOST;
            else
                state_next = DECODE;
        end
    end

    always_comb begin
        host_push = 1'b0;
        adc_load  = 1'b0;
        case (state)
            PUSH_HOST: host_push = 1'b1;
            PUSH_ADC:  adc_load  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr    <= '0;
            wr_ack_count <= '0;
            err_flag     <= 1'b0;
            int_flag     <= 1'b0;
        end else begin
            if (is_echo)
                last_addr <= rsp_payload;
            else if (is_bus_rst)
                last_addr <= '0;
            if (is_ack && (wr_ack_count != '1))
                wr_ack_count <= wr_ack_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (is_err)
                err_flag <= 1'b1;
            else if (err_clr)
                err_flag <= 1'b0;
            if (is_int)
                int_flag <= 1'b1;
            else if (int_clr)
                int_flag <= 1'b0;
        end
    end

    logic [31:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        pop, push_ok;

    assign host_count = wptr - rptr;
    assign host_empty = (wptr == rptr);
    assign host_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign host_dout  = host_empty ? '0 : mem[rptr[AW-1:0]];
    assign pop        = host_rd_en && !host_empty;
    assign push_ok    = host_push && (!host_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr[AW-1:0]] <= payload_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            host_ovf <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + {{AW{1'b0}}, 1'b1};
            if (pop)
                rptr <= rptr + {{AW{1'b0}}, 1'b1};
            if (host_push && !push_ok)
                host_ovf <= 1'b1;
            else if (err_clr)
                host_ovf <= 1'b0;
        end
    end

    // adc_full is honoured in the cycle the strobe would be presented.
    assign adc_wr_en = adc_pend && !adc_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            adc_pend <= 1'b0;
            adc_data <= '0;
            adc_ovf  <= 1'b0;
        end else begin
            adc_pend <= adc_load;
            if (adc_load)
                adc_data <= payload_q;
            if (adc_pend && adc_full)
                adc_ovf <= 1'b1;
            else if (err_clr)
                adc_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_response_decoder.sv
// Directed bench for wb_response_decoder: scoreboard queues hold expected host and ADC
// words (ADC entries carry the cycle they must appear in).
module tb_wb_response_decoder;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rsp_stb;
    logic [33:0] i_rsp_word;
    logic        host_rd_en;
    logic [31:0] host_dout;
    logic        host_empty, host_full;
    logic [4:0]  host_count;
    logic        adc_full;
    logic        adc_wr_en;
    logic [31:0] adc_data;
    logic [31:0] last_addr;
    logic [15:0] wr_ack_count;
    logic        err_clr, int_clr;
    logic        err_flag, int_flag, host_ovf, adc_ovf;

    wb_response_decoder #(
        .DEPTH    (DEPTH),
        .ADC_ADDR (32'h0000_0001),
        .CNT_W    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rsp_stb    (i_rsp_stb),
        .i_rsp_word   (i_rsp_word),
        .host_rd_en   (host_rd_en),
        .host_dout    (host_dout),
        .host_empty   (host_empty),
        .host_full    (host_full),
        .host_count   (host_count),
        .adc_full     (adc_full),
        .adc_wr_en    (adc_wr_en),
        .adc_data     (adc_data),
        .last_addr    (last_addr),
        .wr_ack_count (wr_ack_count),
        .err_clr      (err_clr),
        .int_clr      (int_clr),
        .err_flag     (err_flag),
        .int_flag     (int_flag),
        .host_ovf     (host_ovf),
        .adc_ovf      (adc_ovf)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    logic [31:0] host_q [$];
    logic [63:0] adc_q  [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every adc_wr_en cycle must match the head of the ADC scoreboard.
    always @(negedge clk) begin
        if (adc_wr_en === 1'b1) begin
            if (adc_q.size() == 0) begin
                chk("adc_unexpected", {31'd0, adc_wr_en}, 32'd0);
            end else begin
                logic [63:0] e;
                e = adc_q.pop_front();
                chk("adc_data", adc_data, e[31:0]);
                chk("adc_cycle", cyc, e[63:32]);
            end
        end
    end

    task automatic send(input logic [1:0] t, input logic [31:0] p);
        i_rsp_stb  = 1'b1;
        i_rsp_word = {t, p};
        @(posedge clk); #1;
        i_rsp_stb  = 1'b0;
        i_rsp_word = '0;
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic host_read(input string tag);
        chk(tag, host_dout, host_q.pop_front());
        host_rd_en = 1'b1;
        @(posedge clk); #1;
        host_rd_en = 1'b0;
    endtask

    task automatic pulse_clr(input logic e, input logic i);
        err_clr = e;
        int_clr = i;
        @(posedge clk); #1;
        err_clr = 1'b0;
        int_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_rsp_stb = 1'b0; i_rsp_word = '0; host_rd_en = 1'b0;
        adc_full = 1'b0; err_clr = 1'b0; int_clr = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("rst_empty", {31'd0, host_empty}, 32'd1);
        chk("rst_full", {31'd0, host_full}, 32'd0);
        chk("rst_count", {27'd0, host_count}, 32'd0);
        chk("rst_dout", host_dout, 32'd0);
        chk("rst_adc_wr", {31'd0, adc_wr_en}, 32'd0);
        chk("rst_adc_data", adc_data, 32'd0);
        chk("rst_addr", last_addr, 32'd0);
        chk("rst_acks", {16'd0, wr_ack_count}, 32'd0);
        chk("rst_flags", {28'd0, err_flag, int_flag, host_ovf, adc_ovf}, 32'd0);

        // Host path with latency check
        send(2'b10, 32'h0000_0005);
        chk("echo_addr", last_addr, 32'h5);
        send(2'b01, 32'hAAAA_0001); host_q.push_back(32'hAAAA_0001);
        chk("host_not_yet", {31'd0, host_empty}, 32'd1);
        send(2'b01, 32'hAAAA_0002); host_q.push_back(32'hAAAA_0002);
        chk("host_lat2", {31'd0, host_empty}, 32'd0);
        tick(1);
        chk("host_count2", {27'd0, host_count}, 32'd2);
        host_read("host_w0");
        host_read("host_w1");
        chk("host_drained", {31'd0, host_empty}, 32'd1);

        // ADC path: echo then read on the next cycle
        send(2'b10, 32'h0000_0001);
        send(2'b01, 32'h0000_1234); adc_q.push_back({cyc + 32'd1, 32'h0000_1234});
        tick(4);
        chk("adc_host_empty", {31'd0, host_empty}, 32'd1);
        chk("adc_q_done", adc_q.size(), 32'd0);

        // Host overflow: DEPTH+1 reads without pops
        send(2'b10, 32'h0000_0005);
        for (int unsigned i = 0; i <= DEPTH; i++) begin
            send(2'b01, 32'hB000_0000 + i);
            if (i < DEPTH) host_q.push_back(32'hB000_0000 + i);
        end
        tick(2);
        chk("ovf_full", {31'd0, host_full}, 32'd1);
        chk("ovf_count", {27'd0, host_count}, 32'd16);
        chk("ovf_flag", {31'd0, host_ovf}, 32'd1);
        for (int unsigned i = 0; i < DEPTH; i++) host_read("ovf_word");
        pulse_clr(1'b1, 1'b0);
        chk("ovf_clr", {31'd0, host_ovf}, 32'd0);

        // Full FIFO with a pop on the overflow cycle: nothing dropped
        for (int unsigned i = 0; i < DEPTH; i++) begin
            send(2'b01, 32'hC000_0000 + i);
            host_q.push_back(32'hC000_0000 + i);
        end
        tick(2);
        chk("pp_full", {31'd0, host_full}, 32'd1);
        send(2'b01, 32'hC000_0010); host_q.push_back(32'hC000_0010);
        host_read("pp_head");
        chk("pp_count", {27'd0, host_count}, 32'd16);
        chk("pp_noovf", {31'd0, host_ovf}, 32'd0);
        for (int unsigned i = 0; i < DEPTH; i++) host_read("pp_word");
        chk("pp_empty", {31'd0, host_empty}, 32'd1);

        // ADC back-pressure drops the word
        send(2'b10, 32'h0000_0001);
        adc_full = 1'b1;
        send(2'b01, 32'h0000_0BAD);
        tick(3);
        adc_full = 1'b0;
        chk("adc_ovf_set", {31'd0, adc_ovf}, 32'd1);
        pulse_clr(1'b1, 1'b0);
        chk("adc_ovf_clr", {31'd0, adc_ovf}, 32'd0);

        // Write-ack saturation
        for (int unsigned i = 0; i < 32'hFFFF; i++) send(2'b00, i);
        chk("ack_ffff", {16'd0, wr_ack_count}, 32'hFFFF);
        send(2'b00, 32'h0);
        chk("ack_sat", {16'd0, wr_ack_count}, 32'hFFFF);

        // Specials
        err_clr = 1'b1;
        send(2'b11, 32'd0);
        err_clr = 1'b0;
        chk("err_set_wins", {31'd0, err_flag}, 32'd1);
        pulse_clr(1'b1, 1'b0);
        chk("err_clr", {31'd0, err_flag}, 32'd0);
        send(2'b11, 32'd2);
        chk("int_set", {31'd0, int_flag}, 32'd1);
        pulse_clr(1'b0, 1'b1);
        chk("int_clr", {31'd0, int_flag}, 32'd0);
        send(2'b10, 32'h0000_0077);
        send(2'b11, 32'd7);
        chk("special_other", {30'd0, err_flag, int_flag}, 32'd0);
        chk("special_other_addr", last_addr, 32'h77);
        send(2'b11, 32'd1);
        chk("bus_rst_addr", last_addr, 32'd0);

        // Reset mid-stream: host words queued, ADC write pending, flags set
        send(2'b11, 32'd0);
        send(2'b11, 32'd2);
        send(2'b10, 32'h0000_0005);
        send(2'b01, 32'hD000_0000);
        send(2'b01, 32'hD000_0001);
        send(2'b01, 32'hD000_0002);
        send(2'b10, 32'h0000_0001);
        send(2'b01, 32'hD000_00AD);
        chk("pre_rst_count", {27'd0, host_count}, 32'd3);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_empty", {31'd0, host_empty}, 32'd1);
        chk("mid_rst_count", {27'd0, host_count}, 32'd0);
        chk("mid_rst_adc_wr", {31'd0, adc_wr_en}, 32'd0);
        chk("mid_rst_addr", last_addr, 32'd0);
        chk("mid_rst_flags", {28'd0, err_flag, int_flag, host_ovf, adc_ovf}, 32'd0);
        rst = 1'b0;
        tick(4);
        chk("final_adc_q", adc_q.size(), 32'd0);
        chk("final_empty", {31'd0, host_empty}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_response_decoder.md
Name: wb_response_decoder

Overview:
Return-path companion to the host-to-Wishbone command converter. It accepts the 34-bit response words emitted by the Wishbone bus executor and decodes each word by type. Read data is routed either to a host-readable FIFO (drained through an Opal Kelly pipe/wire) or straight to the ADC data FIFO write port. The block also tracks the last bus address, counts write acknowledgements, and raises sticky status flags.

Parameters:
DEPTH, 16, host read-data FIFO depth in words (power of 2, at least 2)
ADC_ADDR, 32'h0000_0001, bus address whose read data is routed to the ADC FIFO port
CNT_W, 16, width of the write-ack counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
i_rsp_stb  in  1  response word valid, one cycle per word
i_rsp_word  in  34  response: [33:32] type, [31:0] payload
host_rd_en  in  1  pop host FIFO head
host_dout  out  32  host FIFO head, first-word-fall-through
host_empty  out  1  host FIFO empty
host_full  out  1  host FIFO full
host_count  out  clog2(DEPTH)+1  words held
adc_full  in  1  ADC FIFO full (back-pressure)
adc_wr_en  out  1  ADC FIFO write strobe
adc_data  out  32  ADC FIFO write data
last_addr  out  32  most recent address echo
wr_ack_count  out  CNT_W  write acks received, saturating
err_clr  in  1  clear err_flag and ovf flags
int_clr  in  1  clear int_flag
err_flag  out  1  sticky Wishbone bus error
int_flag  out  1  sticky bus interrupt notification
host_ovf  out  1  sticky host FIFO overflow (word dropped)
adc_ovf  out  1  sticky ADC overflow (word dropped)

Behaviour:
- Response type encoding, evaluated only when i_rsp_stb=1:
  - 2'b00 write ack: wr_ack_count+1, saturating at all-ones; payload ignored.
  - 2'b01 read data: if last_addr==ADC_ADDR, go to the ADC path; else go to the host FIFO.
  - 2'b10 address echo: last_addr <= payload. Applies to reads strobed on later cycles.
  - 2'b11 special: payload 0 = bus error (err_flag<=1); payload 1 = bus reset (last_addr<=0); payload 2 = interrupt (int_flag<=1); any other payload is ignored.
- Decode FSM states:
  - IDLE: waits for i_rsp_stb.
  - DECODE: one cycle; captures the word and type.
  - PUSH_HOST: writes the host FIFO.
  - PUSH_ADC: asserts adc_wr_en.
  - Then returns to IDLE.
- The FSM is pipelined so a new strobe is accepted in every state. A back-to-back strobe every cycle is processed without loss.
- Latency:
  - adc_wr_en/adc_data are asserted exactly 2 cycles after the strobe, for 1 cycle.
  - Host FIFO word is visible (host_empty=0, host_dout valid) 2 cycles after the strobe.
  - last_addr, wr_ack_count and flags update 1 cycle after the strobe.
- Address/read ordering: an address echo followed by a read on the next cycle uses the new address. The address update is committed before the routing decision.
- Host FIFO (first-word-fall-through):
  - host_rd_en pops the head; host_rd_en while empty is ignored, count unchanged.
  - Push while full without a same-cycle pop: word dropped, host_ovf<=1.
  - Push and pop on the same cycle while full: both accepted, count unchanged.
  - Pointers wrap modulo DEPTH.
- ADC path: if adc_full=1 on the write cycle, adc_wr_en stays 0, the word is dropped and adc_ovf<=1.
- Clears: a set event in the same cycle as err_clr or int_clr wins, and the flag stays 1.
- Reset values (also when rst is asserted mid-operation): state IDLE, FIFO emptied (host_empty=1, host_full=0, host_count=0, host_dout=0), adc_wr_en=0, adc_data=0, last_addr=0, wr_ack_count=0, all flags 0. Any in-flight word is discarded.

Test Plan:
- Address echo 2'h2/0x00000005, then reads 0xAAAA0001 and 0xAAAA0002 -> host_count=2, host_dout=0xAAAA0001, then 0xAAAA0002 after one pop; adc_wr_en never asserted.
- Address echo 0x00000001, then read 0x00001234 on the next cycle -> adc_wr_en=1 for exactly one cycle, 2 cycles after the strobe, adc_data=0x00001234; host FIFO stays empty.
- DEPTH+1 host reads with no pops -> host_full=1, host_count=16, host_ovf=1, first 16 words intact. Repeat with host_rd_en held on the overflow cycle -> no drop.
- adc_full=1 during an ADC read -> adc_wr_en=0, adc_ovf=1. Assert err_clr -> adc_ovf=0.
- 0x10000 write acks -> wr_ack_count saturates at 0xFFFF. Special 3/0 with err_clr on the same cycle -> err_flag=1. Special 3/2 -> int_flag=1.
- rst mid-stream with 3 words queued and an ADC write pending -> next cycle host_empty=1, adc_wr_en=0, last_addr=0, all flags 0.
